// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer, 8-bit ALU.
// Revision : 1.0
// ============================================================================
module cpu_sequencer #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [7:0]  rf_rdata1,
    input  logic [7:0]  rf_rdata2,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        halted,
    output logic        retire,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_result;
    logic        r_zero;
    logic        r_carry;
    logic        r_rf_we;
    logic        r_retire;
    logic        r_illegal;
    logic        r_halted;

    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic [8:0]  w_sum;
    logic [8:0]  w_diff;
    logic [7:0]  w_result;
    logic        w_zero;
    logic        w_carry;
    logic        w_writes;
    logic        w_illegal;

    assign w_op      = r_ir[15:12];
    assign w_imm     = r_ir[7:0];
    assign w_sum     = {1'b0, rf_rdata1} + {1'b0, rf_rdata2};
    // Bit 8 of the 9-bit difference is the borrow out, i.e. rs1 < rs2.
    assign w_diff    = {1'b0, rf_rdata1} - {1'b0, rf_rdata2};
    assign w_writes  = (w_op != 4'h0) && (w_op <= 4'h7);
    assign w_illegal = (w_op >= 4'h9) && (w_op <= 4'hE);

    always_comb begin
        w_result = r_result;
        w_zero   = r_zero;
        w_carry  = r_carry;
        case (w_op)
            4'h1: w_result = w_imm;
            4'h2: w_result = rf_rdata1;
            4'h3: begin
                w_result = w_sum[7:0];
                w_carry  = w_sum[8];
                w_zero   = (w_sum[7:0] == 8'h00);
            end
            4'h4: begin
                w_result = w_diff[7:0];
                w_carry  = w_diff[8];
                w_zero   = (w_diff[7:0] == 8'h00);
            end
            4'h5: begin
                w_result = rf_rdata1 & rf_rdata2;
                w_carry  = 1'b0;
                w_zero   = ((rf_rdata1 & rf_rdata2) == 8'h00);
            end
            4'h6: begin
                w_result = rf_rdata1 | rf_rdata2;
                w_carry  = 1'b0;
                w_zero   = ((rf_rdata1 | rf_rdata2) == 8'h00);
            end
            4'h7: begin
                w_result = rf_rdata1 ^ rf_rdata2;
                w_carry  = 1'b0;
                w_zero   = ((rf_rdata1 ^ rf_rdata2) == 8'h00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= PC_RESET;
            r_ir      <= 16'h0000;
            r_result  <= 8'h00;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_rf_we   <= 1'b0;
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= S_EXECUTE;
                S_EXECUTE: begin
                    r_result <= w_result;
                    r_zero   <= w_zero;
                    r_carry  <= w_carry;
                    if (w_op == 4'hF) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        // Pulses are set here so they appear exactly in WRITEBACK.
                        r_rf_we   <= w_writes;
                        r_retire  <= 1'b1;
                        r_illegal <= w_illegal;
                        r_state   <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    r_pc    <= (w_op == 4'h8) ? w_imm : r_pc + 8'd1;
                    r_state <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign rf_raddr1  = r_ir[8:6];
    assign rf_raddr2  = r_ir[5:3];
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_ir[11:9];
    assign rf_wdata   = r_result;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign halted     = r_halted;
    assign retire     = r_retire;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire
